rho_rotate_engine: RTL
======================

Name: rho_rotate_engine

Overview:
- Parametrised successor to the fixed 64x25 rotate stage of the matrix encoder (Keccak-style rho step).
- Accepts a state as DEPTH sequential 25-bit slices and buffers it internally.
- Streams the lane-rotated state back out as DEPTH slices with a valid/ready handshake.
- Adds a configurable lane length, an inverse (rotate-right) mode, and backpressure on both sides; sits between the slice memory reader and the next step/writer.

Parameters:
- DEPTH, 64, slices per state (lane length); power of two, 2..64.
- ADDR_W, 6, slice counter width; must equal clog2(DEPTH).
- LANES, 25, bits per slice; fixed at 25, not overridable in use.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new state; sampled only in IDLE.
- inverse  input  1  mode select, captured at start: 0 = forward rho (rotate left), 1 = inverse (rotate right).
- in_valid  input  1  in_slice is valid.
- in_ready  output  1  engine accepts in_slice this cycle.
- in_slice  input  LANES  slice z, bit i = lane i (i = x+5y).
- out_valid  output  1  out_slice/out_addr are valid.
- out_ready  input  1  downstream accepts.
- out_slice  output  LANES  rotated slice.
- out_addr  output  ADDR_W  slice index z of out_slice.
- busy  output  1  high in LOAD and EMIT.
- done  output  1  one-cycle pulse after the last output handshake.

Behaviour:
- Offsets r[i], i = 0..24: 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14; each is applied mod DEPTH.
- Storage: DEPTH x LANES register array, plus ADDR_W counter cnt and captured mode bit m.
- Forward (m=0): out_slice[i] = buf[(z - r[i]) mod DEPTH][i].
- Inverse (m=1): out_slice[i] = buf[(z + r[i]) mod DEPTH][i].
- Index arithmetic: modulo-DEPTH wrap via ADDR_W-bit truncation; no other wrap logic.
- States: IDLE, LOAD, EMIT, DONE.
  - IDLE: in_ready=0, out_valid=0. On start=1: capture m, cnt<=0, go to LOAD.
  - LOAD: in_ready=1. Each in_valid&&in_ready: buf[cnt]<=in_slice, cnt++. The handshake at cnt=DEPTH-1 sets cnt<=0 and goes to EMIT next cycle. in_valid=0 stalls with no change.
  - EMIT: out_valid=1, out_addr=cnt, out_slice computed combinationally from buf and cnt. Each out_valid&&out_ready: cnt++. The handshake at cnt=DEPTH-1 goes to DONE. With out_ready=0, out_slice/out_addr stay stable.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: first out_valid appears 1 cycle after the last input handshake. With continuous valid/ready, throughput is 1 slice/cycle each direction; total 2*DEPTH+2 cycles from start to done.
- start outside IDLE: ignored. inverse changes after start: ignored.
- out_slice driven 0 whenever out_valid=0.
- Reset values: in_ready=0, out_valid=0, out_slice=0, out_addr=0, busy=0, done=0, state=IDLE, cnt=0, m=0. buf contents are not cleared.
- Reset mid-LOAD or mid-EMIT: next cycle IDLE, all outputs at reset values, no done pulse. A subsequent start fully reloads buf.
- start and rst asserted in the same cycle: rst wins.
- Back-to-back: start asserted in the cycle of the done pulse is ignored; start is accepted in the following IDLE cycle.

Test Plan:
- DEPTH=64, forward, one-hot lane 1: buf[0] bit1=1, all else 0 -> lane 1 bit appears only at out_addr=1. A lane 2 bit at z=0 appears at out_addr=62.
- DEPTH=64, inverse applied to forward output -> output equals the original random state on all 64 slices; done pulses once, 130 cycles after start.
- DEPTH=8, forward: r[2]=62 mod 8=6; lane 2 set at z=3 -> appears at out_addr=(3+6) mod 8=1. Lane 0 unchanged.
- Backpressure: random in_valid/out_ready gaps at 50% -> no lost or duplicated slices; out_slice stable while out_valid && !out_ready; out_addr sequence 0..DEPTH-1 in order.
- rst asserted at cnt=20 of LOAD, then a new start with a full state -> outputs match the new state only; no done pulse before the second run's end.
- start pulsed during EMIT and in the done cycle -> ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/rho_rotate_engine.sv
// rho_rotate_engine
//   Buffers one state delivered as DEPTH slices of 25 lane bits, then streams
//   the lane-rotated state back out slice by slice (Keccak-style rho step).
//   Forward mode rotates each lane left by its rho offset; inverse mode
//   rotates right. Offsets are reduced mod DEPTH by ADDR_W-bit truncation.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, inverse        begin a new state (IDLE only), mode captured at start
//   in_valid/in_ready     input slice handshake, in_slice = slice z (bit i = lane x+5y)
//   out_valid/out_ready   output slice handshake, out_slice at index out_addr
//   busy                  high while loading or emitting
//   done                  one-cycle pulse after the last output handshake
module rho_rotate_engine #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned LANES  = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              inverse,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LANES-1:0]  in_slice,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANES-1:0]  out_slice,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done
);

   localparam int unsigned ROT [25] = '{ 0,  1, 62, 28, 27,
                                        36, 44,  6, 55, 20,
                                         3, 10, 43, 25, 39,
                                        41, 45, 15, 21,  8,
                                        18,  2, 61, 56, 14};

   typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              m_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              done_q;
   logic [LANES-1:0]  buf_q [DEPTH];
   logic [LANES-1:0]  out_slice_d;
   logic [ADDR_W-1:0] src_d;
   logic              cnt_last;

   assign cnt_last = (cnt_q == ADDR_W'(DEPTH - 1));

   // Control FSM; handshake/status outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         m_q         <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  m_q        <= inverse;
                  cnt_q      <= '0;
                  state_q    <= LOAD;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  // Counter wraps to 0 on the last slice by truncation.
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_last) begin
                     state_q     <= EMIT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_last) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Slice storage is deliberately not reset; a new start always refills it.
   always_ff @(posedge clk) begin
      if (!rst && in_ready_q && in_valid) begin
         buf_q[cnt_q] <= in_slice;
      end
   end

   // Gather: output lane i at slice z reads stored slice z -/+ r[i] mod DEPTH.
   always_comb begin
      out_slice_d = '0;
      src_d       = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         src_d          = m_q ? (cnt_q + ADDR_W'(ROT[i])) : (cnt_q - ADDR_W'(ROT[i]));
         out_slice_d[i] = buf_q[src_d][i];
      end
      if (!out_valid_q) begin
         out_slice_d = '0;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_slice = out_slice_d;
   assign out_addr  = cnt_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
